tone_arbiter: RTL and testbench
===============================

// Module: tone_arbiter
// PURPOSE
//  Shares the single square-wave tone generator (play) between several sound requesters:
//  game tones, success jingle, game-over jingle and key clicks. Each requester submits
//  one note (frequency + duration). The arbiter grants by fixed priority, times the note
//  in milliseconds, inserts a silent gap, then reports completion.
//  freq_out drives play.freq directly. Multi-note melodies are built by requesters
//  resubmitting one note at a time.
// PARAMETERS
//  IDX_W    2    requester index width; NUM_REQ = 1<<IDX_W (localparam, default 4)
//  DUR_W    10   width of duration and ms counter (max note 2^DUR_W-1 ms)
//  GAP_MS   50   silent gap after every note, in ms (0 = no gap)
// PORTS
//  clk              in   1          system clock
//  rst              in   1          asynchronous, active-high reset
//  ticks_per_milli  in   16         clk cycles per ms; 0 treated as 1
//  req              in   NUM_REQ    request per requester; held until gnt
//  freq_in          in   10*NUM_REQ note Hz of requester i at [10*i +: 10]; 0 = rest
//  dur_in           in   DUR_W*NUM_REQ  note ms of requester i at [DUR_W*i +: DUR_W]
//  gnt              out  NUM_REQ    one-hot, 1-cycle pulse: note of requester i latched
//  done             out  NUM_REQ    one-hot, 1-cycle pulse: note+gap of requester i finished
//  abort            out  NUM_REQ    one-hot, 1-cycle pulse: note preempted (see CONFIGURATION)
//  busy             out  1          high while a note or gap is active
//  freq_out         out  10         frequency to play; 0 = silent
// BEHAVIOUR
//  - Reset (async): state=IDLE; gnt, done, abort, busy, freq_out, counters = 0.
//    Reset mid-note silences the output immediately; there is no resume.
//  - All outputs are registered. Priority is fixed: index 0 is highest.
//  - State IDLE: if req!=0, at edge E0 grant the lowest set index i.
//      gnt[i]=1, latch freq_in[i] and dur_in[i], tick/ms counters cleared, busy=1.
//      If dur>0: freq_out=freq, go to PLAY. If dur==0: freq_out stays 0, go to GAP.
//  - State PLAY: ms counter advances on every ticks_per_milli-th cycle.
//      At E0 + dur*T (T = ticks_per_milli): freq_out=0, go to GAP.
//      If GAP_MS==0, go straight to completion on that same edge.
//  - State GAP: at E0 + (dur+GAP_MS)*T: done[i]=1, busy=0, go to IDLE.
//  - IDLE lasts at least 1 cycle. The next gnt is no earlier than the done edge + 1.
//  - req sampled only in IDLE: a req that drops before gnt is never served.
//    Changes to req, freq_in or dur_in during PLAY/GAP do not affect the active note.
//    A req still high after done is served again, subject to priority.
//  - Simultaneous requests: the lower index wins. Losers keep req high and are served
//    later. Starvation of low priority is acceptable by design.
//  - Arithmetic: ms counter is DUR_W bits and compares equal to the latched dur-1
//    (or GAP_MS-1) on the ms tick. It never wraps because compares stop at the limit.
//    Tick counter is 16 bits, compared against max(ticks_per_milli,1)-1.
//  - Without preemption, abort is constant 0.
// CONFIGURATION
//  TONE_PREEMPT_EN defined:
//    - In PLAY or GAP, if req has a set bit j < owner i, then at the next edge:
//      abort[i]=1, gnt[j]=1; latch j's note, counters cleared, freq_out=freq_in[j]
//      (0 if dur 0).
//    - No gap is inserted and done[i] is never pulsed for the aborted note.
//  TONE_PREEMPT_EN undefined:
//    - abort tied 0; the active note always runs to completion.
// TESTING  (ticks_per_milli=2, GAP_MS=2 unless stated)
//  1. req=0010, f1=262, d1=3 -> gnt[1] at E0; freq_out=262 for E0..E0+5; 0 at E0+6;
//     done[1] at E0+10; busy=0 from E0+10.
//  2. req=1010 same cycle, d=1 each -> gnt[1] at E0, done[1] at E0+6,
//     gnt[3] at E0+7, freq_out=f3.
//  3. req=0001, f0=500, d0=0 -> gnt[0]; freq_out stays 0; done[0] exactly 4 cycles later.
//  4. rst pulsed 1 cycle mid-PLAY -> freq_out, busy, gnt, done = 0 asynchronously;
//     held req[2] is re-granted on the first edge after release.
//  5. TONE_PREEMPT_EN: req[2] playing f=330 d=5, req[0] f=784 rises at ms 1 ->
//     same edge abort[2]=1, gnt[0]=1, freq_out=784, no done[2]. Without the macro:
//     gnt[0] one cycle after done[2].
//  6. ticks_per_milli=0, d=2, GAP_MS=2 -> timing identical to T=1
//     (freq 2 cycles, done at E0+4).

Source files
------------

// File: rtl/tone_arbiter_if.sv
// Request/grant bundle between the sound requesters and tone_arbiter.
// Requesters use the master modport and the arbiter uses the slave modport.
`timescale 1ns/1ps
interface tone_arbiter_if #(
  parameter int IDX_W = 2,
  parameter int DUR_W = 10
);
  localparam int NUM_REQ = 1 << IDX_W;

  logic [NUM_REQ-1:0]       req;
  logic [10*NUM_REQ-1:0]    freq_in;
  logic [DUR_W*NUM_REQ-1:0] dur_in;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       abort;
  logic                     busy;
  logic [9:0]               freq_out;

  modport master (
    output req, freq_in, dur_in,
    input  gnt, done, abort, busy, freq_out
  );

  modport slave (
    input  req, freq_in, dur_in,
    output gnt, done, abort, busy, freq_out
  );
endinterface

// File: rtl/tone_arbiter.sv
// Fixed-priority owner of the square-wave tone generator: grants one note at a time,
// times it in milliseconds, adds a silent gap, then pulses done. TONE_PREEMPT_EN enables preemption.
`timescale 1ns/1ps
module tone_arbiter #(
  parameter int IDX_W  = 2,
  parameter int DUR_W  = 10,
  parameter int GAP_MS = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ticks_per_milli,
  tone_arbiter_if.slave bus
);
  localparam int NUM_REQ = 1 << IDX_W;
  localparam logic [DUR_W-1:0] GAP_LAST = (GAP_MS > 0) ? DUR_W'(GAP_MS - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [DUR_W-1:0]   dur_reg, dur_next;
  logic [15:0]        tick_cnt_reg, tick_next;
  logic [DUR_W-1:0]   ms_cnt_reg, ms_next;
  logic [9:0]         freq_reg, freq_next;
  logic               busy_reg, busy_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [NUM_REQ-1:0] abort_reg, abort_next;

  logic [9:0]         freq_arr [NUM_REQ];
  logic [DUR_W-1:0]   dur_arr  [NUM_REQ];
  logic [IDX_W-1:0]   win_idx;
  logic               req_any;
  logic [15:0]        tick_max;
  logic               ms_tick;
  logic               start;
  logic               finish;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign freq_arr[gi] = bus.freq_in[10*gi +: 10];
      assign dur_arr[gi]  = bus.dur_in[DUR_W*gi +: DUR_W];
    end
  endgenerate

  // Lowest set index wins; it is also the preemption candidate when below the owner.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_idx = IDX_W'(i);
      end
    end
  end

  assign req_any  = |bus.req;
  assign tick_max = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
  assign ms_tick  = (tick_cnt_reg == tick_max);

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    dur_next   = dur_reg;
    tick_next  = tick_cnt_reg;
    ms_next    = ms_cnt_reg;
    freq_next  = freq_reg;
    busy_next  = busy_reg;
    gnt_next   = '0;
    done_next  = '0;
    abort_next = '0;
    start      = 1'b0;
    finish     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        start = req_any;
      end

      S_PLAY: begin
        tick_next = ms_tick ? 16'd0 : tick_cnt_reg + 16'd1;
        if (ms_tick) begin
          if (ms_cnt_reg == dur_reg - DUR_W'(1)) begin
            freq_next = '0;
            ms_next   = '0;
            if (GAP_MS == 0) begin
              finish = 1'b1;
            end else begin
              state_next = S_GAP;
            end
          end else begin
            ms_next = ms_cnt_reg + DUR_W'(1);
          end
        end
      end

      S_GAP: begin
        tick_next = ms_tick ? 16'd0 : tick_cnt_reg + 16'd1;
        if (GAP_MS == 0) begin
          finish = 1'b1;
        end else if (ms_tick) begin
          if (ms_cnt_reg == GAP_LAST) begin
            finish = 1'b1;
          end else begin
            ms_next = ms_cnt_reg + DUR_W'(1);
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (finish) begin
      done_next[owner_reg] = 1'b1;
      busy_next  = 1'b0;
      state_next = S_IDLE;
      tick_next  = '0;
      ms_next    = '0;
    end

`ifdef TONE_PREEMPT_EN
    // A higher-priority request replaces the owner outright; the aborted note gets no gap or done.
    if (state_reg != S_IDLE && req_any && win_idx < owner_reg) begin
      abort_next[owner_reg] = 1'b1;
      done_next = '0;
      start     = 1'b1;
    end
`endif

    if (start) begin
      gnt_next[win_idx] = 1'b1;
      owner_next = win_idx;
      dur_next   = dur_arr[win_idx];
      tick_next  = '0;
      ms_next    = '0;
      busy_next  = 1'b1;
      if (dur_arr[win_idx] != '0) begin
        freq_next  = freq_arr[win_idx];
        state_next = S_PLAY;
      end else begin
        freq_next  = '0;
        state_next = S_GAP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      owner_reg    <= '0;
      dur_reg      <= '0;
      tick_cnt_reg <= '0;
      ms_cnt_reg   <= '0;
      freq_reg     <= '0;
      busy_reg     <= 1'b0;
      gnt_reg      <= '0;
      done_reg     <= '0;
      abort_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      dur_reg      <= dur_next;
      tick_cnt_reg <= tick_next;
      ms_cnt_reg   <= ms_next;
      freq_reg     <= freq_next;
      busy_reg     <= busy_next;
      gnt_reg      <= gnt_next;
      done_reg     <= done_next;
      abort_reg    <= abort_next;
    end
  end

  assign bus.gnt      = gnt_reg;
  assign bus.done     = done_reg;
  assign bus.abort    = abort_reg;
  assign bus.busy     = busy_reg;
  assign bus.freq_out = freq_reg;
endmodule

// File: tb/tb_tone_arbiter.sv
// Self-checking bench for tone_arbiter: directed scenarios plus randomized requesters
// compared against a timeline model (grant edge + duration arithmetic).
`timescale 1ns/1ps
module tb_tone_arbiter;
  localparam int IDX_W   = 2;
  localparam int DUR_W   = 10;
  localparam int GAP_MS  = 2;
  localparam int NUM_REQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ticks_per_milli;

  tone_arbiter_if #(.IDX_W(IDX_W), .DUR_W(DUR_W)) bus();

  tone_arbiter #(.IDX_W(IDX_W), .DUR_W(DUR_W), .GAP_MS(GAP_MS)) dut (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (ticks_per_milli),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // timeline model state for the random test
  int n_edge   = 0;
  bit m_active = 1'b0;
  int m_owner, m_g, m_d, m_f;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (got no finish, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_note(input int i, input int f, input int d);
    bus.freq_in[10*i +: 10]      = 10'(f);
    bus.dur_in[DUR_W*i +: DUR_W] = DUR_W'(d);
  endtask

  function automatic logic [22:0] snap();
    return {bus.gnt, bus.done, bus.abort, bus.busy, bus.freq_out};
  endfunction

  function automatic logic [22:0] mk(input logic [3:0] g, input logic [3:0] d,
                                     input logic [3:0] a, input logic b, input int f);
    return {g, d, a, b, 10'(f)};
  endfunction

  function automatic string fmt(input logic [22:0] s);
    return $sformatf("gnt=%b done=%b abort=%b busy=%b freq=%0d",
                     s[22:19], s[18:15], s[14:11], s[10], s[9:0]);
  endfunction

  task automatic test_reset();
    logic [22:0] exp;
    rst = 1'b1;
    ticks_per_milli = 16'd2;
    bus.req = '0;
    bus.freq_in = '0;
    bus.dur_in = '0;
    #2;
    exp = mk(4'b0, 4'b0, 4'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (snap() !== exp) begin
        tests_failed++;
        $display("FAIL reset k=%0d got %s want %s", k, fmt(snap()), fmt(exp));
      end
      step();
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    tests_run++;
    if (snap() !== exp) begin
      tests_failed++;
      $display("FAIL reset_idle got %s want %s", fmt(snap()), fmt(exp));
    end
    $display("[TB] reset: outputs idle after release");
  endtask

  task automatic test_single_note();
    logic [22:0] exp;
    bus.req = 4'b0010;
    set_note(1, 262, 3);
    step();
    exp = mk(4'b0010, 4'b0, 4'b0, 1'b1, 262);
    tests_run++;
    if (snap() !== exp) begin
      tests_failed++;
      $display("FAIL single_gnt got %s want %s", fmt(snap()), fmt(exp));
    end
    bus.req = '0;
    for (int k = 1; k <= 11; k++) begin
      step();
      exp = mk(4'b0, (k == 10) ? 4'b0010 : 4'b0, 4'b0, k < 10, (k <= 5) ? 262 : 0);
      tests_run++;
      if (snap() !== exp) begin
        tests_failed++;
        $display("FAIL single k=%0d got %s want %s", k, fmt(snap()), fmt(exp));
      end
    end
    $display("[TB] single_note: req1 f=262 d=3 done at E0+10");
  endtask

  task automatic test_priority();
    logic [22:0] exp;
    int f;
    bus.req = 4'b1010;
    set_note(1, 300, 1);
    set_note(3, 440, 1);
    for (int k = 0; k <= 14; k++) begin
      step();
      if (k == 0) bus.req = 4'b1000;
      if (k == 7) bus.req = 4'b0000;
      f = (k <= 1) ? 300 : ((k == 7 || k == 8) ? 440 : 0);
      exp = mk((k == 0) ? 4'b0010 : ((k == 7) ? 4'b1000 : 4'b0),
               (k == 6) ? 4'b0010 : ((k == 13) ? 4'b1000 : 4'b0),
               4'b0, (k < 6) || (k >= 7 && k < 13), f);
      tests_run++;
      if (snap() !== exp) begin
        tests_failed++;
        $display("FAIL priority k=%0d got %s want %s", k, fmt(snap()), fmt(exp));
      end
    end
    $display("[TB] priority: req1 then req3 granted one cycle after done");
  endtask

  task automatic test_zero_dur();
    logic [22:0] exp;
    bus.req = 4'b0001;
    set_note(0, 500, 0);
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k == 0) bus.req = 4'b0;
      exp = mk((k == 0) ? 4'b0001 : 4'b0, (k == 4) ? 4'b0001 : 4'b0, 4'b0, k < 4, 0);
      tests_run++;
      if (snap() !== exp) begin
        tests_failed++;
        $display("FAIL zero_dur k=%0d got %s want %s", k, fmt(snap()), fmt(exp));
      end
    end
    $display("[TB] zero_dur: req0 rest note, done 4 cycles after gnt");
  endtask

  task automatic test_zero_ticks();
    logic [22:0] exp;
    ticks_per_milli = 16'd0;
    bus.req = 4'b0010;
    set_note(1, 100, 2);
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k == 0) bus.req = 4'b0;
      exp = mk((k == 0) ? 4'b0010 : 4'b0, (k == 4) ? 4'b0010 : 4'b0, 4'b0, k < 4,
               (k <= 1) ? 100 : 0);
      tests_run++;
      if (snap() !== exp) begin
        tests_failed++;
        $display("FAIL zero_ticks k=%0d got %s want %s", k, fmt(snap()), fmt(exp));
      end
    end
    ticks_per_milli = 16'd2;
    $display("[TB] zero_ticks: T=0 behaves as T=1");
  endtask

  task automatic test_reset_mid_play();
    logic [22:0] exp;
    bus.req = 4'b0100;
    set_note(2, 330, 5);
    step();
    exp = mk(4'b0100, 4'b0, 4'b0, 1'b1, 330);
    tests_run++;
    if (snap() !== exp) begin
      tests_failed++;
      $display("FAIL rst_mid_gnt got %s want %s", fmt(snap()), fmt(exp));
    end
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    exp = mk(4'b0, 4'b0, 4'b0, 1'b0, 0);
    tests_run++;
    if (snap() !== exp) begin
      tests_failed++;
      $display("FAIL rst_mid_async got %s want %s", fmt(snap()), fmt(exp));
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      step();
      if (k == 0) bus.req = 4'b0;
      exp = mk((k == 0) ? 4'b0100 : 4'b0, (k == 14) ? 4'b0100 : 4'b0, 4'b0, k < 14,
               (k <= 9) ? 330 : 0);
      tests_run++;
      if (snap() !== exp) begin
        tests_failed++;
        $display("FAIL rst_mid_regrant k=%0d got %s want %s", k, fmt(snap()), fmt(exp));
      end
    end
    $display("[TB] reset_mid_play: held req2 re-granted after release");
  endtask

  task automatic test_preempt();
    logic [22:0] exp;
    bus.req = 4'b0100;
    set_note(2, 330, 5);
    step();
    bus.req = 4'b0;
    step();
    step();
    bus.req = 4'b0001;
    set_note(0, 784, 1);
`ifdef TONE_PREEMPT_EN
    for (int k = 0; k <= 7; k++) begin
      step();
      if (k == 0) bus.req = 4'b0;
      exp = mk((k == 0) ? 4'b0001 : 4'b0, (k == 6) ? 4'b0001 : 4'b0,
               (k == 0) ? 4'b0100 : 4'b0, k < 6, (k <= 1) ? 784 : 0);
      tests_run++;
      if (snap() !== exp) begin
        tests_failed++;
        $display("FAIL preempt k=%0d got %s want %s", k, fmt(snap()), fmt(exp));
      end
    end
    $display("[TB] preempt: req0 aborts req2 at ms 1");
`else
    for (int k = 3; k <= 22; k++) begin
      step();
      if (k == 15) bus.req = 4'b0;
      exp = mk((k == 15) ? 4'b0001 : 4'b0,
               (k == 14) ? 4'b0100 : ((k == 21) ? 4'b0001 : 4'b0), 4'b0,
               (k < 14) || (k >= 15 && k < 21),
               (k <= 9) ? 330 : ((k == 15 || k == 16) ? 784 : 0));
      tests_run++;
      if (snap() !== exp) begin
        tests_failed++;
        $display("FAIL no_preempt k=%0d got %s want %s", k, fmt(snap()), fmt(exp));
      end
    end
    $display("[TB] no_preempt: req0 waits for done of req2");
`endif
  endtask

  // One clock of the random run: advance the timeline model, compare, then drive requesters.
  task automatic rand_cycle(input bit draining);
    int lowest, te;
    bit do_grant;
    logic [3:0] eg, ed, ea;
    logic [22:0] exp;
    step();
    n_edge++;
    te = (ticks_per_milli == 16'd0) ? 1 : int'(ticks_per_milli);
    lowest = -1;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (bus.req[i]) lowest = i;
    eg = '0; ed = '0; ea = '0;
    do_grant = 1'b0;
    if (m_active) begin
`ifdef TONE_PREEMPT_EN
      if (lowest >= 0 && lowest < m_owner) begin
        ea[m_owner] = 1'b1;
        do_grant = 1'b1;
      end else
`endif
      if (n_edge == m_g + (m_d + GAP_MS) * te) begin
        ed[m_owner] = 1'b1;
        m_active = 1'b0;
      end
    end else if (lowest >= 0) begin
      do_grant = 1'b1;
    end
    if (do_grant) begin
      eg[lowest] = 1'b1;
      m_active = 1'b1;
      m_owner = lowest;
      m_g = n_edge;
      m_d = int'(bus.dur_in[DUR_W*lowest +: DUR_W]);
      m_f = int'(bus.freq_in[10*lowest +: 10]);
      $display("[TB] rand cyc=%0d gnt[%0d] f=%0d d=%0d T=%0d", n_edge, lowest, m_f, m_d, te);
    end
    exp = mk(eg, ed, ea, m_active, (m_active && n_edge < m_g + m_d * te) ? m_f : 0);
    tests_run++;
    if (snap() !== exp) begin
      tests_failed++;
      $display("FAIL random cyc=%0d got %s want %s", n_edge, fmt(snap()), fmt(exp));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (eg[i]) begin
        set_note(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 6)));
        bus.req[i] = !draining && ($urandom_range(0, 2) == 0);
      end else if (!bus.req[i]) begin
        if (!draining && $urandom_range(0, 7) == 0) begin
          set_note(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 6)));
          bus.req[i] = 1'b1;
        end
      end else if ($urandom_range(0, 31) == 0) begin
        bus.req[i] = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    int budget;
    for (int phase = 0; phase < 4; phase++) begin
      ticks_per_milli = 16'(phase);
      for (int c = 0; c < 200; c++) rand_cycle(1'b0);
      budget = 0;
      while ((m_active || bus.req != '0) && budget < 400) begin
        rand_cycle(1'b1);
        budget++;
      end
      tests_run++;
      if (m_active || bus.req != '0) begin
        tests_failed++;
        $display("FAIL random_drain phase=%0d got busy after %0d cycles want idle", phase, budget);
      end
    end
    ticks_per_milli = 16'd2;
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_priority();
    test_zero_dur();
    test_zero_ticks();
    test_reset_mid_play();
    test_preempt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
